lab8_soc_key_event_in: RTL and testbench



---
 rtl/lab8_soc_key_event_pkg.sv | 27 ++
 rtl/lab8_soc_key_fifo.sv | 65 ++++++
 rtl/lab8_soc_key_event_in.sv | 107 ++++++++++
 tb/tb_lab8_soc_key_event_in.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/lab8_soc_key_event_pkg.sv
// Shared register map and bit positions for the key/event input port.
package lab8_soc_key_event_pkg;

  // Register word offsets
  localparam logic [1:0] REG_DATA     = 2'd0;
  localparam logic [1:0] REG_STATUS   = 2'd1;
  localparam logic [1:0] REG_IRQ_MASK = 2'd2;
  localparam logic [1:0] REG_CTRL     = 2'd3;

  // DATA / STATUS bit positions
  localparam int unsigned DATA_VALID_BIT   = 31;
  localparam int unsigned STATUS_EMPTY_BIT = 16;
  localparam int unsigned STATUS_FULL_BIT  = 17;
  localparam int unsigned STATUS_OVF_BIT   = 18;

  // IRQ_MASK / CTRL bit positions
  localparam int unsigned MASK_NE_BIT    = 0;
  localparam int unsigned MASK_OVF_BIT   = 1;
  localparam int unsigned CTRL_FLUSH_BIT = 0;

  // Interrupt mask register layout (bit 1 = overflow, bit 0 = not-empty)
  typedef struct packed {
    logic ovf_en;
    logic ne_en;
  } irq_mask_t;

endpackage

// File: rtl/lab8_soc_key_fifo.sv
// Synchronous FIFO for event codes with push, pop and flush.
//   push/push_data : write at tail (accepted when not full, or full with a pop)
//   pop            : remove head (ignored when empty)
//   flush          : clear pointers and count; overrides push and pop
//   head           : head entry, 0 when empty
//   count/empty/full : occupancy
module lab8_soc_key_fifo #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned PTR_W  = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              flush,
  output logic [DATA_W-1:0] head,
  output logic [PTR_W:0]    count,
  output logic              empty,
  output logic              full
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    cnt;
  logic              pop_ok;
  logic              push_ok;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (PTR_W+1)'(DEPTH));
  assign count   = cnt;
  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign head    = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + (PTR_W+1)'(1);
        2'b01:   cnt <= cnt - (PTR_W+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage array, not reset
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/lab8_soc_key_event_in.sv
// Avalon-MM slave exposing a FIFO of hardware key/event codes to the CPU.
//   address/chipselect/read_n/write_n/writedata : bus slave port
//   readdata : zero-latency read data (0 when not selected)
//   in_data/in_valid : event code push from fabric, no back-pressure
//   irq : registered level interrupt
module lab8_soc_key_event_in
  import lab8_soc_key_event_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned PTR_W  = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              read_n,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              irq
);

  logic              rd;
  logic              wr;
  logic              pop;
  logic              flush;
  logic              ovf_set;
  logic              ovf_clr;
  logic [DATA_W-1:0] head;
  logic [PTR_W:0]    count;
  logic              empty;
  logic              full;
  logic              overflow_q;
  irq_mask_t         mask_q;
  logic              irq_q;
  logic              unused_wdata;

  assign rd      = chipselect & ~read_n;
  assign wr      = chipselect & ~write_n;
  assign pop     = rd & (address == REG_DATA);
  assign flush   = wr & (address == REG_CTRL) & writedata[CTRL_FLUSH_BIT];
  assign ovf_clr = wr & (address == REG_STATUS) & writedata[STATUS_OVF_BIT];
  // Drop only when full with no pop; a flush in the same cycle discards the push silently
  assign ovf_set = in_valid & full & ~pop & ~flush;
  assign unused_wdata = ^writedata;

  lab8_soc_key_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (in_valid),
    .push_data (in_data),
    .pop       (pop),
    .flush     (flush),
    .head      (head),
    .count     (count),
    .empty     (empty),
    .full      (full)
  );

  // Sticky overflow (set beats clear), mask register and registered irq
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q <= 1'b0;
      mask_q     <= '0;
      irq_q      <= 1'b0;
    end else begin
      if (ovf_set)      overflow_q <= 1'b1;
      else if (ovf_clr) overflow_q <= 1'b0;
      if (wr && address == REG_IRQ_MASK) begin
        mask_q.ne_en  <= writedata[MASK_NE_BIT];
        mask_q.ovf_en <= writedata[MASK_OVF_BIT];
      end
      irq_q <= (mask_q.ne_en & ~empty) | (mask_q.ovf_en & overflow_q);
    end
  end

  assign irq = irq_q;

  // Read mux
  always_comb begin
    readdata = '0;
    if (chipselect) begin
      case (address)
        REG_DATA: begin
          readdata                 = 32'(head);
          readdata[DATA_VALID_BIT] = ~empty;
        end
        REG_STATUS: begin
          readdata                   = 32'(count);
          readdata[STATUS_EMPTY_BIT] = empty;
          readdata[STATUS_FULL_BIT]  = full;
          readdata[STATUS_OVF_BIT]   = overflow_q;
        end
        REG_IRQ_MASK: readdata = 32'(mask_q);
        default:      readdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_lab8_soc_key_event_in.sv
// Directed vector bench for lab8_soc_key_event_in.
module tb_lab8_soc_key_event_in;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [15:0] in_data;
  logic        in_valid;
  logic        irq;

  int checks;
  int failures;

  lab8_soc_key_event_in #(.DATA_W(16), .DEPTH(8), .PTR_W(3)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .read_n     (read_n),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  addr;
    logic        cs;
    logic        rd;
    logic        wr;
    logic [31:0] wdata;
    logic        iv;
    logic [15:0] idata;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic [1:0] a, logic cs, logic r, logic w, logic [31:0] wd,
                              logic iv, logic [15:0] d, logic chk, logic [31:0] e, logic ei);
    vec_t v;
    v.addr = a; v.cs = cs; v.rd = r; v.wr = w; v.wdata = wd;
    v.iv = iv; v.idata = d; v.chk_rd = chk; v.exp_rd = e; v.exp_irq = ei;
    return v;
  endfunction

  function automatic vec_t v_rd(logic [1:0] a, logic [31:0] e, logic ei);
    return mk(a, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 16'h0, 1'b1, e, ei);
  endfunction
  function automatic vec_t v_rdpush(logic [1:0] a, logic [15:0] d, logic [31:0] e, logic ei);
    return mk(a, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, d, 1'b1, e, ei);
  endfunction
  function automatic vec_t v_wr(logic [1:0] a, logic [31:0] wd, logic ei);
    return mk(a, 1'b1, 1'b0, 1'b1, wd, 1'b0, 16'h0, 1'b0, 32'h0, ei);
  endfunction
  function automatic vec_t v_wrpush(logic [1:0] a, logic [31:0] wd, logic [15:0] d, logic ei);
    return mk(a, 1'b1, 1'b0, 1'b1, wd, 1'b1, d, 1'b0, 32'h0, ei);
  endfunction
  function automatic vec_t v_push(logic [15:0] d, logic ei);
    return mk(2'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, d, 1'b1, 32'h0, ei);
  endfunction
  function automatic vec_t v_idle(logic ei);
    return mk(2'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 16'h0, 1'b1, 32'h0, ei);
  endfunction

  task automatic check32(string what, int id, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s #%0d: got 0x%08h expected 0x%08h", what, id, act, exp);
    end
  endtask

  task automatic drive_idle();
    address = 2'd0; chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
    writedata = 32'h0; in_valid = 1'b0; in_data = 16'h0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(vec_t v, int id);
    address = v.addr; chipselect = v.cs; read_n = ~v.rd; write_n = ~v.wr;
    writedata = v.wdata; in_valid = v.iv; in_data = v.idata;
    @(negedge clk);
    if (v.chk_rd) check32("readdata", id, readdata, v.exp_rd);
    check32("irq", id, 32'(irq), 32'(v.exp_irq));
    step();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    drive_idle();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    step();

    // Reset state
    vq.push_back(v_rd(2'd0, 32'h0000_0000, 1'b0));
    vq.push_back(v_rd(2'd1, 32'h0001_0000, 1'b0));
    vq.push_back(v_rd(2'd2, 32'h0000_0000, 1'b0));
    vq.push_back(v_rd(2'd3, 32'h0000_0000, 1'b0));
    // Three pushes, read back in order, then empty
    vq.push_back(v_push(16'h0041, 1'b0));
    vq.push_back(v_push(16'h0042, 1'b0));
    vq.push_back(v_push(16'h001C, 1'b0));
    vq.push_back(v_rd(2'd1, 32'h0000_0003, 1'b0));
    vq.push_back(v_rd(2'd0, 32'h8000_0041, 1'b0));
    vq.push_back(v_rd(2'd0, 32'h8000_0042, 1'b0));
    vq.push_back(v_rd(2'd0, 32'h8000_001C, 1'b0));
    vq.push_back(v_rd(2'd0, 32'h0000_0000, 1'b0));
    vq.push_back(v_rd(2'd1, 32'h0001_0000, 1'b0));
    // Writes to DATA are ignored
    vq.push_back(v_wr(2'd0, 32'hFFFF_FFFF, 1'b0));
    vq.push_back(v_rd(2'd1, 32'h0001_0000, 1'b0));
    // Nine pushes into eight entries -> overflow, then W1C
    for (int i = 0; i < 9; i++) vq.push_back(v_push(16'h0100 + 16'(i), 1'b0));
    vq.push_back(v_rd(2'd1, 32'h0006_0008, 1'b0));
    vq.push_back(v_wr(2'd1, 32'h0004_0000, 1'b0));
    vq.push_back(v_rd(2'd1, 32'h0002_0008, 1'b0));
    // Full: pop and push in the same cycle
    vq.push_back(v_rdpush(2'd0, 16'h00AA, 32'h8000_0100, 1'b0));
    vq.push_back(v_rd(2'd1, 32'h0002_0008, 1'b0));
    for (int i = 1; i < 8; i++) vq.push_back(v_rd(2'd0, 32'h8000_0100 + 32'(i), 1'b0));
    vq.push_back(v_rd(2'd0, 32'h8000_00AA, 1'b0));
    vq.push_back(v_rd(2'd1, 32'h0001_0000, 1'b0));
    // Not-empty interrupt, one cycle of lag each way
    vq.push_back(v_wr(2'd2, 32'h0000_0001, 1'b0));
    vq.push_back(v_rd(2'd2, 32'h0000_0001, 1'b0));
    vq.push_back(v_push(16'h0050, 1'b0));
    vq.push_back(v_idle(1'b0));
    vq.push_back(v_rd(2'd0, 32'h8000_0050, 1'b1));
    vq.push_back(v_idle(1'b1));
    vq.push_back(v_idle(1'b0));
    // Overflow interrupt until W1C
    vq.push_back(v_wr(2'd2, 32'h0000_0002, 1'b0));
    for (int i = 0; i < 9; i++) vq.push_back(v_push(16'h0200 + 16'(i), 1'b0));
    vq.push_back(v_idle(1'b0));
    vq.push_back(v_idle(1'b1));
    vq.push_back(v_wr(2'd1, 32'h0004_0000, 1'b1));
    vq.push_back(v_idle(1'b1));
    vq.push_back(v_idle(1'b0));
    vq.push_back(v_rd(2'd1, 32'h0002_0008, 1'b0));
    // New overflow and W1C in the same cycle: set wins
    vq.push_back(v_wrpush(2'd1, 32'h0004_0000, 16'h0F0F, 1'b0));
    vq.push_back(v_rd(2'd1, 32'h0006_0008, 1'b0));
    vq.push_back(v_idle(1'b1));
    vq.push_back(v_wr(2'd1, 32'h0004_0000, 1'b1));
    vq.push_back(v_idle(1'b1));
    vq.push_back(v_idle(1'b0));
    // Flush with a push: flush wins, no overflow
    vq.push_back(v_wrpush(2'd3, 32'h0000_0001, 16'h0300, 1'b0));
    vq.push_back(v_rd(2'd1, 32'h0001_0000, 1'b0));
    vq.push_back(v_rd(2'd0, 32'h0000_0000, 1'b0));
    vq.push_back(v_rd(2'd3, 32'h0000_0000, 1'b0));
    // Empty read with simultaneous push
    vq.push_back(v_rdpush(2'd0, 16'h0077, 32'h0000_0000, 1'b0));
    vq.push_back(v_rd(2'd1, 32'h0000_0001, 1'b0));
    vq.push_back(v_rd(2'd0, 32'h8000_0077, 1'b0));
    vq.push_back(v_rd(2'd1, 32'h0001_0000, 1'b0));
    // Mask register keeps only two bits
    vq.push_back(v_wr(2'd2, 32'hFFFF_FFFF, 1'b0));
    vq.push_back(v_rd(2'd2, 32'h0000_0003, 1'b0));

    foreach (vq[i]) apply(vq[i], i);

    // Five pushes with not-empty irq enabled, then asynchronous reset mid-burst
    drive_idle();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 16'h0400 + 16'(i);
      step();
    end
    in_valid = 1'b0;
    begin
      int waited;
      waited = 0;
      while (irq !== 1'b1 && waited < 10) begin
        step();
        waited++;
      end
      checks++;
      if (irq !== 1'b1) begin
        failures++;
        $display("FAIL irq_wait: got %b expected 1 within 10 cycles", irq);
      end
    end
    chipselect = 1'b1; read_n = 1'b0; address = 2'd1;
    in_valid = 1'b1; in_data = 16'h0500;
    #1;
    check32("status_before_reset", 0, readdata, 32'h0000_0005);
    #2 reset_n = 1'b0;
    #1;
    check32("status_in_reset", 0, readdata, 32'h0001_0000);
    check32("irq_in_reset", 0, 32'(irq), 32'h0);
    address = 2'd2;
    #1;
    check32("mask_in_reset", 0, readdata, 32'h0000_0000);
    address = 2'd0;
    #1;
    check32("data_in_reset", 0, readdata, 32'h0000_0000);
    in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    step();
    address = 2'd1;
    #1;
    check32("status_after_reset", 0, readdata, 32'h0001_0000);
    check32("irq_after_reset", 0, 32'(irq), 32'h0);

    drive_idle();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
